// File: rtl/pb_cursor_ctrl.sv
// Cursor position controller for four debounced direction buttons: single-step on press,
// auto-repeat while held. The step decision is registered one cycle before the position update.
module pb_cursor_ctrl #(
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479,
  parameter int X_INIT     = 320,
  parameter int Y_INIT     = 240,
  parameter int STEP       = 1,
  parameter int DELAY_CYC  = 25000000,
  parameter int REPEAT_CYC = 5000000,
  parameter int WRAP       = 0,
  parameter int CW         = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_state,
  input  logic [3:0] btn_down,
  output logic [9:0] cur_x,
  output logic [8:0] cur_y,
  output logic       move_pulse,
  output logic [1:0] active_dir
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]      r_dir, w_dir_nxt;
  logic            r_step_p0, w_step;
  logic [1:0]      r_sdir_p0, w_sdir;
  logic [9:0]      r_x, w_x_nxt;
  logic [8:0]      r_y, w_y_nxt;
  logic            r_mv, w_mv_nxt;
  logic            w_held;
  logic [3:0]      w_other;

  // Lowest index wins: U > D > L > R.
  function automatic logic [1:0] f_prio(input logic [3:0] v);
    if (v[0])      f_prio = 2'd0;
    else if (v[1]) f_prio = 2'd1;
    else if (v[2]) f_prio = 2'd2;
    else           f_prio = 2'd3;
  endfunction

  function automatic logic [9:0] f_dec(input logic [9:0] v, input logic [9:0] mx);
    if (v < 10'(STEP)) f_dec = (WRAP != 0) ? mx : 10'd0;
    else               f_dec = v - 10'(STEP);
  endfunction

  function automatic logic [9:0] f_inc(input logic [9:0] v, input logic [9:0] mx);
    if (v > mx - 10'(STEP)) f_inc = (WRAP != 0) ? 10'd0 : mx;
    else                    f_inc = v + 10'(STEP);
  endfunction

  assign w_held  = btn_state[r_dir];
  assign w_other = btn_down & ~(4'b0001 << r_dir);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dir     <= 2'd0;
      r_step_p0 <= 1'b0;
      r_sdir_p0 <= 2'd0;
      r_x       <= 10'(X_INIT);
      r_y       <= 9'(Y_INIT);
      r_mv      <= 1'b0;
    end else begin
      // p0: step decision; p1: position update from the registered decision
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dir     <= w_dir_nxt;
      r_step_p0 <= w_step;
      r_sdir_p0 <= w_sdir;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_mv      <= w_mv_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_step      = 1'b0;
    w_sdir      = r_dir;
    case (r_state)
      S_IDLE: begin
        if (|btn_down) begin
          w_step      = 1'b1;
          w_sdir      = f_prio(btn_down);
          w_dir_nxt   = f_prio(btn_down);
          w_cnt_nxt   = '0;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (!w_held) begin
          w_cnt_nxt = '0;
          if (|btn_down) begin
            w_step      = 1'b1;
            w_sdir      = f_prio(btn_down);
            w_dir_nxt   = f_prio(btn_down);
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (|w_other) begin
          w_step      = 1'b1;
          w_sdir      = f_prio(w_other);
          w_dir_nxt   = f_prio(w_other);
          w_cnt_nxt   = '0;
          w_state_nxt = S_HOLD;
        end else if (r_state == S_HOLD) begin
          if (r_cnt == CW'(DELAY_CYC - 1)) begin
            w_step      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_REPEAT;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          if (r_cnt == CW'(REPEAT_CYC - 1)) begin
            w_step    = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (r_step_p0) begin
      case (r_sdir_p0)
        2'd0:    w_y_nxt = 9'(f_dec({1'b0, r_y}, 10'(Y_MAX)));
        2'd1:    w_y_nxt = 9'(f_inc({1'b0, r_y}, 10'(Y_MAX)));
        2'd2:    w_x_nxt = f_dec(r_x, 10'(X_MAX));
        default: w_x_nxt = f_inc(r_x, 10'(X_MAX));
      endcase
    end
    // A saturated step leaves the position alone and raises no pulse.
    w_mv_nxt = r_step_p0 && ((w_x_nxt != r_x) || (w_y_nxt != r_y));
  end

  assign cur_x      = r_x;
  assign cur_y      = r_y;
  assign move_pulse = r_mv;
  assign active_dir = r_dir;

endmodule

// File: tb/tb_pb_cursor_ctrl.sv
// Scoreboard bench for pb_cursor_ctrl: a saturating instance and a wrapping instance,
// expected moves queued by the stimulus and matched by per-instance monitors.
module tb_pb_cursor_ctrl;

  typedef struct {
    int cyc;
    int x;
    int y;
    int d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] bs0 = '0, bd0 = '0, bs1 = '0, bd1 = '0;
  logic [9:0] x0, x1;
  logic [8:0] y0, y1;
  logic       mv0, mv1;
  logic [1:0] d0, d1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pb_cursor_ctrl #(.X_MAX(15), .Y_MAX(7), .X_INIT(8), .Y_INIT(4), .STEP(1),
    .DELAY_CYC(8), .REPEAT_CYC(4), .WRAP(0), .CW(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .btn_state(bs0), .btn_down(bd0),
    .cur_x(x0), .cur_y(y0), .move_pulse(mv0), .active_dir(d0));

  pb_cursor_ctrl #(.X_MAX(15), .Y_MAX(7), .X_INIT(8), .Y_INIT(4), .STEP(1),
    .DELAY_CYC(8), .REPEAT_CYC(4), .WRAP(1), .CW(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .btn_state(bs1), .btn_down(bd1),
    .cur_x(x1), .cur_y(y1), .move_pulse(mv1), .active_dir(d1));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int c, input int x, input int y, input int d);
    exp_t e;
    e.cyc = c; e.x = x; e.y = y; e.d = d;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (mv0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL sat_unexpected cyc=%0d x=%0d y=%0d dir=%0d", cyc, x0, y0, d0);
        end else begin
          exp_t e;
          e = q0.pop_front();
          if (e.cyc != cyc || e.x != int'(x0) || e.y != int'(y0) || e.d != int'(d0)) begin
            errors++;
            $display("FAIL sat_move got cyc=%0d x=%0d y=%0d dir=%0d expected cyc=%0d x=%0d y=%0d dir=%0d",
                     cyc, x0, y0, d0, e.cyc, e.x, e.y, e.d);
          end
        end
      end else if (q0.size() > 0 && q0[0].cyc < cyc) begin
        exp_t e;
        e = q0.pop_front();
        checks++;
        errors++;
        $display("FAIL sat_missing got no pulse by cyc=%0d expected cyc=%0d x=%0d y=%0d", cyc, e.cyc, e.x, e.y);
      end
      if (mv1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL wrap_unexpected cyc=%0d x=%0d y=%0d dir=%0d", cyc, x1, y1, d1);
        end else begin
          exp_t e;
          e = q1.pop_front();
          if (e.cyc != cyc || e.x != int'(x1) || e.y != int'(y1) || e.d != int'(d1)) begin
            errors++;
            $display("FAIL wrap_move got cyc=%0d x=%0d y=%0d dir=%0d expected cyc=%0d x=%0d y=%0d dir=%0d",
                     cyc, x1, y1, d1, e.cyc, e.x, e.y, e.d);
          end
        end
      end else if (q1.size() > 0 && q1[0].cyc < cyc) begin
        exp_t e;
        e = q1.pop_front();
        checks++;
        errors++;
        $display("FAIL wrap_missing got no pulse by cyc=%0d expected cyc=%0d x=%0d y=%0d", cyc, e.cyc, e.x, e.y);
      end
    end
  end

  initial begin
    int t;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("rst_x0", x0, 8);   chk("rst_y0", y0, 4);
    chk("rst_mv0", mv0, 0); chk("rst_dir0", d0, 0);
    chk("rst_x1", x1, 8);   chk("rst_y1", y1, 4);

    // Single R press held 3 cycles: one step, no repeat.
    t = cyc; bd0 = 4'b1000; bs0 = 4'b1000; q0.push_back(mk(t + 2, 9, 4, 3));
    tick(1); bd0 = '0;
    tick(2); bs0 = '0;
    tick(20);

    // Asynchronous reset mid-run.
    rst_n = 1'b0;
    #2;
    chk("arst_x0", x0, 8);   chk("arst_y0", y0, 4);
    chk("arst_mv0", mv0, 0); chk("arst_dir0", d0, 0);
    tick(2); rst_n = 1'b1; tick(2);

    // U held: press step, first repeat at +8, then every 4, saturated at 0.
    t = cyc; bd0 = 4'b0001; bs0 = 4'b0001;
    q0.push_back(mk(t + 2, 8, 3, 0));
    q0.push_back(mk(t + 10, 8, 2, 0));
    q0.push_back(mk(t + 14, 8, 1, 0));
    q0.push_back(mk(t + 18, 8, 0, 0));
    tick(1); bd0 = '0;
    tick(20); bs0 = '0;
    tick(5);

    // D press, then U and D together: U wins.
    t = cyc; bd0 = 4'b0010; bs0 = 4'b0010; q0.push_back(mk(t + 2, 8, 1, 1));
    tick(1); bd0 = '0; bs0 = '0; tick(4);
    t = cyc; bd0 = 4'b0011; bs0 = 4'b0011; q0.push_back(mk(t + 2, 8, 0, 0));
    tick(1); bd0 = '0; bs0 = '0; tick(4);

    // L held, R pressed 5 cycles after the L step; R keeps repeating after L is released.
    t = cyc; bd0 = 4'b0100; bs0 = 4'b0100;
    q0.push_back(mk(t + 2, 7, 0, 2));
    tick(1); bd0 = '0;
    tick(4); bd0 = 4'b1000; bs0 = 4'b1100;
    q0.push_back(mk(t + 7, 8, 0, 3));
    q0.push_back(mk(t + 15, 9, 0, 3));
    q0.push_back(mk(t + 19, 10, 0, 3));
    q0.push_back(mk(t + 23, 11, 0, 3));
    tick(1); bd0 = '0; bs0 = 4'b1000;
    tick(18); bs0 = '0;
    tick(5);

    // Wrapping instance: walk x to 15, then R wraps to 0 and L wraps back to 15.
    for (int i = 0; i < 8; i++) begin
      t = cyc; bd1 = 4'b1000; bs1 = 4'b1000;
      q1.push_back(mk(t + 2, (i < 7) ? 9 + i : 0, 4, 3));
      tick(1); bd1 = '0; bs1 = '0;
      tick(2);
    end
    t = cyc; bd1 = 4'b0100; bs1 = 4'b0100; q1.push_back(mk(t + 2, 15, 4, 2));
    tick(1); bd1 = '0; bs1 = '0; tick(3);

    // U held, then released in the same cycle as a D press: D steps and enters HOLD.
    t = cyc; bd1 = 4'b0001; bs1 = 4'b0001;
    q1.push_back(mk(t + 2, 15, 3, 0));
    tick(1); bd1 = '0;
    tick(2); bd1 = 4'b0010; bs1 = 4'b0010;
    q1.push_back(mk(t + 5, 15, 4, 1));
    q1.push_back(mk(t + 13, 15, 5, 1));
    tick(1); bd1 = '0;
    tick(10); bs1 = '0;
    tick(8);

    chk("sat_queue_empty", q0.size(), 0);
    chk("wrap_queue_empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
